// File: rtl/div_unit32_if.sv
// Issue/result bus between the execute stage and the iterative divider.
// The core drives the request side (master); the divider drives status and result (slave).
interface div_unit32_if;
  logic        i_divStart_1;
  logic [1:0]  i_divOp_2;
  logic [31:0] i_divDividend_32;
  logic [31:0] i_divDivisor_32;
  logic        o_divBusy_1;
  logic        o_divValid_1;
  logic [31:0] o_divResult_32;

  modport master (
    output i_divStart_1,
    output i_divOp_2,
    output i_divDividend_32,
    output i_divDivisor_32,
    input  o_divBusy_1,
    input  o_divValid_1,
    input  o_divResult_32
  );

  modport slave (
    input  i_divStart_1,
    input  i_divOp_2,
    input  i_divDividend_32,
    input  i_divDivisor_32,
    output o_divBusy_1,
    output o_divValid_1,
    output o_divResult_32
  );
endinterface

// File: rtl/div_unit32.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN resolves divide-by-zero and signed overflow without iterating.

module Adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cIn,
  output logic [31:0] sum,
  output logic        cOut
);
  logic [3:0][8:0] sumZeroAll;
  logic [3:0][8:0] sumOneAll;
  logic            carryWalk;

  // Each byte precomputes both carry-in outcomes; the incoming carry only selects.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gBlock
      assign sumZeroAll[gi] = {1'b0, a[gi*8 +: 8]} + {1'b0, b[gi*8 +: 8]};
      assign sumOneAll[gi]  = {1'b0, a[gi*8 +: 8]} + {1'b0, b[gi*8 +: 8]} + 9'd1;
    end
  endgenerate

  always_comb begin
    carryWalk = cIn;
    sum       = '0;
    for (int k = 0; k < 4; k++) begin
      sum[k*8 +: 8] = carryWalk ? sumOneAll[k][7:0] : sumZeroAll[k][7:0];
      carryWalk     = carryWalk ? sumOneAll[k][8]   : sumZeroAll[k][8];
    end
    cOut = carryWalk;
  end
endmodule

module div_unit32 (
  input  logic         i_clk_1,
  input  logic         i_rst_1,
  div_unit32_if.slave  divBus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} divState_t;

  divState_t   stateReg;
  logic [1:0]  opReg;
  logic [31:0] remReg;
  logic [31:0] quotReg;
  logic [31:0] divisorReg;
  logic [31:0] dividendReg;
  logic        quotSignReg;
  logic        remSignReg;
  logic        divZeroReg;
  logic        overflowReg;
  logic [4:0]  cntReg;
  logic        busyReg;
  logic        validReg;
  logic [31:0] resultReg;

  logic        startSigned;
  logic        dividendNeg;
  logic        divisorNeg;
  logic [31:0] dividendMag;
  logic [31:0] divisorMag;
  logic        startDivZero;
  logic        startOverflow;
  logic        earlyOut;
  logic [31:0] earlyResult;

  logic [31:0] trialDiff;
  logic        trialCarry;
  logic        noBorrow;
  logic [31:0] remNext;
  logic [31:0] quotNext;
  logic [31:0] quotFixed;
  logic [31:0] remFixed;
  logic [31:0] calcResult;

  always_comb begin
    startSigned   = ~divBus.i_divOp_2[0];
    dividendNeg   = startSigned & divBus.i_divDividend_32[31];
    divisorNeg    = startSigned & divBus.i_divDivisor_32[31];
    dividendMag   = dividendNeg ? (~divBus.i_divDividend_32 + 32'd1) : divBus.i_divDividend_32;
    divisorMag    = divisorNeg  ? (~divBus.i_divDivisor_32  + 32'd1) : divBus.i_divDivisor_32;
    startDivZero  = (divBus.i_divDivisor_32 == 32'd0);
    startOverflow = startSigned && (divBus.i_divDividend_32 == 32'h8000_0000) &&
                    (divBus.i_divDivisor_32 == 32'hFFFF_FFFF);
    if (divBus.i_divOp_2[1])
      earlyResult = startDivZero ? divBus.i_divDividend_32 : 32'd0;
    else
      earlyResult = startDivZero ? 32'hFFFF_FFFF : 32'h8000_0000;
  end

`ifdef DIV_EARLY_OUT_EN
  assign earlyOut = startDivZero | startOverflow;
`else
  assign earlyOut = 1'b0;
`endif

  // Trial subtraction of the divisor magnitude from the low 32 bits of {rem, quot[31]}.
  Adder trialSub (
    .a    ({remReg[30:0], quotReg[31]}),
    .b    (~divisorReg),
    .cIn  (1'b1),
    .sum  (trialDiff),
    .cOut (trialCarry)
  );

  always_comb begin
    noBorrow  = remReg[31] | trialCarry;
    remNext   = noBorrow ? trialDiff : {remReg[30:0], quotReg[31]};
    quotNext  = {quotReg[30:0], noBorrow};
    quotFixed = quotSignReg ? (~quotNext + 32'd1) : quotNext;
    remFixed  = remSignReg  ? (~remNext  + 32'd1) : remNext;
    // Special cases override whatever the iteration produced.
    if (divZeroReg)
      calcResult = opReg[1] ? dividendReg : 32'hFFFF_FFFF;
    else if (overflowReg)
      calcResult = opReg[1] ? 32'd0 : 32'h8000_0000;
    else
      calcResult = opReg[1] ? remFixed : quotFixed;
  end

  always_ff @(posedge i_clk_1) begin
    if (i_rst_1) begin
      stateReg    <= IDLE;
      opReg       <= '0;
      remReg      <= '0;
      quotReg     <= '0;
      divisorReg  <= '0;
      dividendReg <= '0;
      quotSignReg <= 1'b0;
      remSignReg  <= 1'b0;
      divZeroReg  <= 1'b0;
      overflowReg <= 1'b0;
      cntReg      <= '0;
      busyReg     <= 1'b0;
      validReg    <= 1'b0;
      resultReg   <= '0;
    end else begin
      case (stateReg)
        IDLE, DONE: begin
          validReg <= 1'b0;
          if (divBus.i_divStart_1) begin
            opReg       <= divBus.i_divOp_2;
            remReg      <= '0;
            quotReg     <= dividendMag;
            divisorReg  <= divisorMag;
            dividendReg <= divBus.i_divDividend_32;
            quotSignReg <= dividendNeg ^ divisorNeg;
            remSignReg  <= dividendNeg;
            divZeroReg  <= startDivZero;
            overflowReg <= startOverflow;
            cntReg      <= '0;
            if (earlyOut) begin
              stateReg  <= DONE;
              validReg  <= 1'b1;
              resultReg <= earlyResult;
            end else begin
              stateReg  <= CALC;
              busyReg   <= 1'b1;
            end
          end else begin
            stateReg <= IDLE;
          end
        end
        CALC: begin
          remReg  <= remNext;
          quotReg <= quotNext;
          cntReg  <= cntReg + 5'd1;
          // The last iteration's outcome is corrected and registered on the same edge.
          if (cntReg == 5'd31) begin
            stateReg  <= DONE;
            busyReg   <= 1'b0;
            validReg  <= 1'b1;
            resultReg <= calcResult;
          end
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          validReg <= 1'b0;
        end
      endcase
    end
  end

  assign divBus.o_divBusy_1    = busyReg;
  assign divBus.o_divValid_1   = validReg;
  assign divBus.o_divResult_32 = resultReg;
endmodule

// File: tb/tb_div_unit32.sv
// Directed bench for div_unit32: hand-computed results, latency, busy/valid pulse shape,
// result hold between ops, start ignored while busy, reset mid-op and back-to-back issue.
module tb_div_unit32;
  logic clk = 1'b0;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;
  logic [31:0] lastResult;

`ifdef DIV_EARLY_OUT_EN
  localparam int SP_LAT  = 1;
  localparam int SP_BUSY = 0;
`else
  localparam int SP_LAT  = 33;
  localparam int SP_BUSY = 32;
`endif

  div_unit32_if divBus ();

  div_unit32 dut (
    .i_clk_1 (clk),
    .i_rst_1 (rst),
    .divBus  (divBus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    assert (got === exp) else begin
      failCount++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Caller is positioned at a negedge; start is seen at the following posedge (cycle 0).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    divBus.i_divStart_1     = 1'b1;
    divBus.i_divOp_2        = op;
    divBus.i_divDividend_32 = a;
    divBus.i_divDivisor_32  = b;
    @(posedge clk);
    #1;
    divBus.i_divStart_1     = 1'b0;
    divBus.i_divDividend_32 = $urandom;
    divBus.i_divDivisor_32  = $urandom;
  endtask

  task automatic waitValid(input int intrude, input logic [31:0] holdVal,
                           output int lat, output int busyCnt, output int overlap, output int holdBad);
    lat = -1; busyCnt = 0; overlap = 0; holdBad = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (divBus.o_divBusy_1 === 1'b1) busyCnt++;
      if (divBus.o_divBusy_1 === 1'b1 && divBus.o_divValid_1 === 1'b1) overlap++;
      if (divBus.o_divValid_1 === 1'b1) begin
        lat = n;
        break;
      end
      if (divBus.o_divResult_32 !== holdVal) holdBad++;
      if (n == intrude) begin
        divBus.i_divStart_1     = 1'b1;
        divBus.i_divOp_2        = 2'b01;
        divBus.i_divDividend_32 = 32'd9;
        divBus.i_divDivisor_32  = 32'd3;
      end else if (n == intrude + 1) begin
        divBus.i_divStart_1 = 1'b0;
      end
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int expLat,
                       input int expBusy, input int intrude);
    int lat, bc, ov, hb;
    @(negedge clk);
    issue(op, a, b);
    waitValid(intrude, lastResult, lat, bc, ov, hb);
    check({tag, " result"}, divBus.o_divResult_32, exp);
    check({tag, " latency"}, 32'(lat), 32'(expLat));
    check({tag, " busy cycles"}, 32'(bc), 32'(expBusy));
    check({tag, " busy/valid overlap"}, 32'(ov), 32'd0);
    check({tag, " result hold"}, 32'(hb), 32'd0);
    @(negedge clk);
    check({tag, " valid one cycle"}, {31'd0, divBus.o_divValid_1}, 32'd0);
    check({tag, " result after pulse"}, divBus.o_divResult_32, exp);
    lastResult = exp;
  endtask

  initial begin
    int lat, bc, ov, hb, validSeen;
    rst                     = 1'b1;
    divBus.i_divStart_1     = 1'b0;
    divBus.i_divOp_2        = 2'b00;
    divBus.i_divDividend_32 = '0;
    divBus.i_divDivisor_32  = '0;
    lastResult              = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, divBus.o_divBusy_1}, 32'd0);
    check("reset valid", {31'd0, divBus.o_divValid_1}, 32'd0);
    check("reset result", divBus.o_divResult_32, 32'd0);
    rst = 1'b0;

    runOp("DIVU 100/7",      2'b01, 32'd100,       32'd7,         32'd14,        33, 32, 0);
    runOp("REMU 100/7",      2'b11, 32'd100,       32'd7,         32'd2,         33, 32, 0);
    runOp("REM -7/2",        2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 32, 0);
    runOp("DIV -7/2",        2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 32, 0);
    runOp("DIV -100/7",      2'b00, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 33, 32, 0);
    runOp("REM -100/7",      2'b10, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 33, 32, 0);
    runOp("DIV 7/-2",        2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 32, 0);
    runOp("REM 7/-2",        2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 32, 0);
    runOp("DIVU max/16",     2'b01, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33, 32, 0);
    runOp("REMU max/16",     2'b11, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F, 33, 32, 0);
    runOp("DIVU 8000/FFFF",  2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, 32, 0);
    runOp("REMU 8000/FFFF",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32, 0);
    runOp("DIV overflow",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT, SP_BUSY, 0);
    runOp("REM overflow",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SP_LAT, SP_BUSY, 0);
    runOp("DIVU 5/0",        2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF, SP_LAT, SP_BUSY, 0);
    runOp("REMU 5/0",        2'b11, 32'd5,         32'd0,         32'd5,         SP_LAT, SP_BUSY, 0);
    runOp("DIV 5/0",         2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, SP_LAT, SP_BUSY, 0);
    runOp("REM -5/0",        2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, SP_LAT, SP_BUSY, 0);
    runOp("start in CALC",   2'b01, 32'd1000,      32'd10,        32'd100,       33, 32, 5);

    // Reset asserted in cycle 10 of an op: the op vanishes without a valid pulse.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset busy", {31'd0, divBus.o_divBusy_1}, 32'd0);
    check("mid reset valid", {31'd0, divBus.o_divValid_1}, 32'd0);
    check("mid reset result", divBus.o_divResult_32, 32'd0);
    rst = 1'b0;
    validSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (divBus.o_divValid_1 === 1'b1) validSeen++;
    end
    check("mid reset no valid", 32'(validSeen), 32'd0);
    lastResult = 32'd0;

    // Back-to-back: second start in the DONE cycle of the first op.
    @(negedge clk);
    issue(2'b01, 32'd100, 32'd7);
    waitValid(0, lastResult, lat, bc, ov, hb);
    check("b2b first result", divBus.o_divResult_32, 32'd14);
    check("b2b first latency", 32'(lat), 32'd33);
    issue(2'b01, 32'd81, 32'd9);
    waitValid(0, 32'd14, lat, bc, ov, hb);
    check("b2b second result", divBus.o_divResult_32, 32'd9);
    check("b2b second latency", 32'(lat), 32'd33);
    check("b2b busy cycles", 32'(bc), 32'd32);
    check("b2b first result held", 32'(hb), 32'd0);
    check("b2b overlap", 32'(ov), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule

// File: doc/div_unit32.md
# div_unit32

- Iterative 32-bit radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU ops.
- Inverse-direction companion to the existing 32-bit carry-select `Adder` module. One `Adder` instance performs the per-iteration trial subtraction: operand2 inverted, carry-in 1.
- Sits beside the ALU in the execute stage. The core issues an op with a start pulse, stalls while busy, and captures the result on a one-cycle valid pulse.

## Interface
Parameters: none (width fixed at 32).

Ports:
- i_clk_1  in  1  clock. Single clock domain; all state updates on the rising edge.
- i_rst_1  in  1  reset, synchronous, active-high.
- i_divStart_1  in  1  start request; sampled only when the unit can accept.
- i_divOp_2  in  2  operation select. Equals funct3[1:0].
  - 00 = DIV
  - 01 = DIVU
  - 10 = REM
  - 11 = REMU
- i_divDividend_32  in  32  rs1 value.
- i_divDivisor_32  in  32  rs2 value.
- o_divBusy_1  out  1  high while iterating (CALC state).
- o_divValid_1  out  1  one-cycle pulse; o_divResult_32 is final while this is high.
- o_divResult_32  out  32  quotient or remainder, registered. Holds its value until the next op completes.

## Operation
States: IDLE, CALC, DONE.

- **IDLE or DONE with i_divStart_1 = 1:**
  - Latch op and operands.
  - Convert signed operands (op[0] = 0) to magnitudes.
  - Record quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
  - Clear the partial remainder; load the dividend magnitude into the quotient shift register.
  - Set the iteration counter to 0 and go to CALC.
- **CALC, one quotient bit per cycle:**
  - Form the 33-bit value S = {remainder[31:0], quotient[31]}.
  - Trial-subtract the divisor magnitude using the Adder (A = S[31:0], B = ~divisor, cIn = 1).
  - No-borrow = S[32] OR cOut.
  - If no-borrow: remainder = difference, new quotient bit = 1. Otherwise: remainder = S[31:0], new quotient bit = 0.
  - Shift the quotient left, inserting the new bit.
  - After counter = 31, go to DONE.
- **DONE:**
  - Apply sign correction (two's-complement negate where the recorded sign is 1).
  - Select quotient (op[1] = 0) or remainder (op[1] = 1).
  - Register the result into o_divResult_32 and pulse o_divValid_1.
  - Next state: CALC if i_divStart_1 = 1, else IDLE.
- **Special cases, overriding the datapath result in DONE:**
  - Divisor = 0: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend, unmodified.
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **i_divStart_1 in CALC:** ignored, no queueing. The caller must hold ops while o_divBusy_1 = 1.

## Timing
- **Reset values:** i_rst_1 = 1 at any edge, including mid-CALC, forces IDLE.
  - o_divBusy_1 = 0
  - o_divValid_1 = 0
  - o_divResult_32 = 0
  - Counter and internal registers = 0
  - Any op in flight is discarded with no valid pulse.
- **Normal latency:** start seen high at the edge ending cycle 0.
  - o_divBusy_1 = 1 in cycles 1–32.
  - o_divValid_1 = 1 in cycle 33 only, with the result present from that cycle.
- **Back-to-back:** a start in the DONE cycle (cycle 33) is accepted. Busy rises in cycle 34 and the next valid pulse is in cycle 66.
- o_divBusy_1 and o_divValid_1 are never high in the same cycle.
- Operand inputs need only be stable in the start cycle.

## Configuration
Macro: DIV_EARLY_OUT_EN.

- **Defined:** divide-by-zero and signed overflow are detected at start.
  - The FSM skips CALC and goes IDLE→DONE.
  - Start in cycle 0 gives o_divValid_1 in cycle 1; o_divBusy_1 stays 0.
  - Results are identical to the special-case values above.
- **Not defined:** every op takes the full 33-cycle path. Special cases are resolved only by the DONE override.

## Test plan
- **DIVU 100 / 7:** start in cycle 0 -> valid only in cycle 33, result 14. Repeat as REMU -> 2.
- **REM −7 / 2** (0xFFFFFFF9, 0x00000002) -> 0xFFFFFFFF. DIV on the same operands -> 0xFFFFFFFD.
- **Special cases:**
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
  - DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5.
  - Latency is cycle 33 without DIV_EARLY_OUT_EN and cycle 1 with it.
- **Reset mid-op:** i_rst_1 high in cycle 10 of CALC -> next cycle busy = 0, result = 0, and no valid pulse ever appears for that op.
- **Start during CALC:** a second start in cycle 5 is ignored, and the first result arrives in cycle 33 unaffected.
- **Back-to-back:** a new start in the DONE cycle 33 -> second valid in cycle 66 with the correct second result. o_divResult_32 holds the first result between the two pulses.
